// File: rtl/profile_ci_multi_if.sv
// CI port bundle for profile_ci_multi: CPU-side strobe, operands and completion/result.
interface profile_ci_multi_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/profile_ci_multi.sv
// Profiling custom instruction: NUM_COUNTERS masked event counters, one read per CI call.
// Optional macro PROFILE_SATURATE_EN: counters hold at all-ones instead of wrapping.
module profile_ci_multi #(
  parameter logic [7:0]  customId     = 8'h00,
  parameter int unsigned NUM_COUNTERS = 4,
  parameter int unsigned WIDTH        = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                busIdle,
  input  logic [7:0]          eventIn,
  profile_ci_multi_if.slave   ci
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]              state;
  logic [0:0]              state_nxt;
  logic                    accept_c;
  logic [31:0]             result_q;
  logic [31:0]             rd_c;
  logic [WIDTH-1:0]        cnt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] en;
  logic [NUM_COUNTERS-1:0] en_nxt_c;
  logic [NUM_COUNTERS-1:0] clr_c;
  logic [NUM_COUNTERS-1:0] src_c;
  logic                    unused_c;

  // Operand and event bits that no counter consumes.
  assign unused_c = ^{ci.valueA[31:3], ci.valueB, eventIn};

  // Next-state: accept a matching start only from IDLE; DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (ci.start && (ci.ciN == customId)) begin
          accept_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Event sources, control masks and read mux (out-of-range index reads 0).
  always_comb begin
    src_c    = '0;
    en_nxt_c = en;
    clr_c    = '0;
    rd_c     = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (i == 0)      src_c[i] = 1'b1;
      else if (i == 1) src_c[i] = stall;
      else if (i == 2) src_c[i] = busIdle;
      else             src_c[i] = eventIn[i];
      if (accept_c) begin
        en_nxt_c[i] = (en[i] | ci.valueB[i]) & ~ci.valueB[8+i];
        clr_c[i]    = ci.valueB[16+i];
      end
      if (ci.valueA[2:0] == 3'(i)) rd_c = 32'(cnt[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      result_q <= accept_c ? rd_c : 32'd0;
    end
  end

  // Counters use the pre-acceptance enables; clear overrides a same-edge increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) cnt[i] <= '0;
    end else begin
      en <= en_nxt_c;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (clr_c[i]) begin
          cnt[i] <= '0;
        end else if (en[i] && src_c[i]) begin
`ifdef PROFILE_SATURATE_EN
          if (cnt[i] != '1) cnt[i] <= cnt[i] + WIDTH'(1);
`else
          cnt[i] <= cnt[i] + WIDTH'(1);
`endif
        end
      end
    end
  end

  assign ci.done   = (state == DONE);
  assign ci.result = result_q;

endmodule

// File: tb/tb_profile_ci_multi.sv
// Scoreboard bench for profile_ci_multi: a 32-bit and an 8-bit instance share one CI stream.
module tb_profile_ci_multi;

  localparam logic [7:0] ID  = 8'h00;
  localparam logic [7:0] BAD = 8'h05;

  typedef struct {
    string       name;
    logic [31:0] e32;
    logic [31:0] e8;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       stall;
  logic       busIdle;
  logic [7:0] eventIn;
  int         checks;
  int         errors;
  exp_t       sbq [$];

  profile_ci_multi_if bus32 ();
  profile_ci_multi_if bus8 ();

  assign bus8.start  = bus32.start;
  assign bus8.ciN    = bus32.ciN;
  assign bus8.valueA = bus32.valueA;
  assign bus8.valueB = bus32.valueB;

  profile_ci_multi #(.customId(ID), .NUM_COUNTERS(4), .WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .stall(stall), .busIdle(busIdle),
    .eventIn(eventIn), .ci(bus32)
  );

  profile_ci_multi #(.customId(ID), .NUM_COUNTERS(4), .WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .stall(stall), .busIdle(busIdle),
    .eventIn(eventIn), .ci(bus8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model8(input int unsigned v);
`ifdef PROFILE_SATURATE_EN
    return (v > 255) ? 32'd255 : 32'(v);
`else
    return 32'(v % 256);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One CI call; expected read value (true count) goes to the scoreboard before the accepting edge.
  task automatic ci(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                    input bit expect_done, input int unsigned exp, input string name);
    @(negedge clock);
    bus32.start  = 1'b1;
    bus32.ciN    = id;
    bus32.valueA = a;
    bus32.valueB = b;
    if (expect_done) sbq.push_back('{name, 32'(exp), model8(exp)});
    @(negedge clock);
    bus32.start  = 1'b0;
    bus32.valueA = '0;
    bus32.valueB = '0;
    #1;
    if (expect_done) begin
      chk({name, "_pending"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end else begin
      chk({name, "_nodone"}, 32'({bus8.done, bus32.done}), 32'd0);
    end
  endtask

  // Monitor: every done pops one expectation; result must be 0 whenever done is low.
  always @(negedge clock) begin
    exp_t e;
    if (bus32.done || bus8.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'({bus8.done, bus32.done}), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_done"}, 32'({bus8.done, bus32.done}), 32'd3);
        chk({e.name, "_w32"}, bus32.result, e.e32);
        chk({e.name, "_w8"}, bus8.result, e.e8);
      end
    end else begin
      chk("idle_result", bus32.result | bus8.result, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    stall = 1'b0;
    busIdle = 1'b0;
    eventIn = '0;
    bus32.start = 1'b0;
    bus32.ciN = '0;
    bus32.valueA = '0;
    bus32.valueB = '0;
    repeat (3) @(negedge clock);
    chk("rst_done", 32'({bus8.done, bus32.done}), 32'd0);
    chk("rst_result", bus32.result | bus8.result, 32'd0);
    reset = 1'b1;

    // Idle after reset: every counter reads 0.
    idle(10);
    for (int i = 0; i < 4; i++) ci(32'(i), 32'h0, ID, 1, 0, $sformatf("t1_rd%0d", i));

    // Cycle counter: read after idle(n) following the enable returns n+1.
    ci(0, 32'h0000_0001, ID, 1, 0, "t2_en0");
    idle(99);
    ci(0, 32'h0, ID, 1, 100, "t2_cnt0");

    // Stall counter and out-of-range indices.
    ci(1, 32'h0000_0002, ID, 1, 0, "t3_en1");
    stall = 1'b1;
    repeat (37) @(negedge clock);
    stall = 1'b0;
    ci(1, 32'h0, ID, 1, 37, "t3_cnt1");
    ci(5, 32'h0, ID, 1, 0, "t3_idx5");
    ci(7, 32'h0, ID, 1, 0, "t3_idx7");

    // Bus-idle counter ignores eventIn[2].
    ci(2, 32'h0000_0004, ID, 1, 0, "t3_en2");
    busIdle = 1'b1;
    eventIn = 8'hF7;
    repeat (12) @(negedge clock);
    busIdle = 1'b0;
    eventIn = '0;
    idle(3);
    ci(2, 32'h0, ID, 1, 12, "t3_cnt2");

    // External event counter with a gapped pulse pattern.
    ci(3, 32'h0000_0008, ID, 1, 0, "t3_en3");
    eventIn = 8'h08;
    repeat (5) @(negedge clock);
    eventIn = '0;
    idle(4);
    eventIn = 8'h08;
    repeat (3) @(negedge clock);
    eventIn = '0;
    ci(3, 32'h0, ID, 1, 8, "t3_cnt3");

    // Wrong CI number: no done, no clear.
    ci(1, 32'h00FF_FF00, BAD, 0, 0, "t4_badid");
    ci(1, 32'h0, ID, 1, 37, "t4_keep1");
    ci(3, 32'h0, ID, 1, 8, "t4_keep3");

    // Clear only counter 1: read returns pre-clear value.
    ci(1, 32'h0002_0000, ID, 1, 37, "t4_clr1");
    ci(1, 32'h0, ID, 1, 0, "t4_after_clr1");
    ci(3, 32'h0, ID, 1, 8, "t4_other3");

    // Disable+clear, then enable+disable in one call: counter 0 stays stopped.
    ci(1, 32'h0001_0100, ID, 1, 0, "t4_dis0");
    ci(1, 32'h0000_0101, ID, 1, 0, "t4_endis0");
    idle(10);
    ci(0, 32'h0, ID, 1, 0, "t4_stopped0");

    // Clear while counting: pre-clear value, then count since clear.
    ci(1, 32'h0000_0001, ID, 1, 0, "t4_en0");
    idle(20);
    ci(0, 32'h0001_0000, ID, 1, 21, "t4_clr0");
    idle(15);
    ci(0, 32'h0, ID, 1, 16, "t4_since_clr");

    // Start held into DONE: second cycle is ignored (no second done, no second clear).
    @(negedge clock);
    bus32.start  = 1'b1;
    bus32.ciN    = ID;
    bus32.valueA = 0;
    bus32.valueB = 32'h0001_0000;
    sbq.push_back('{"t4_hold", 32'd18, model8(18)});
    @(negedge clock);
    @(negedge clock);
    bus32.start  = 1'b0;
    bus32.valueB = '0;
    #1;
    chk("t4_hold_nodone", 32'({bus8.done, bus32.done}), 32'd0);
    chk("t4_hold_pending", 32'(sbq.size()), 32'd0);
    sbq.delete();
    ci(0, 32'h0, ID, 1, 2, "t4_hold_cnt");

    // Long run: 8-bit instance wraps (or saturates).
    ci(1, 32'h0001_0000, ID, 1, 0, "t5_clr0");
    idle(299);
    ci(0, 32'h0, ID, 1, 300, "t5_cnt0");

    // Reset asserted while done is high.
    @(negedge clock);
    bus32.start  = 1'b1;
    bus32.ciN    = ID;
    bus32.valueA = 0;
    bus32.valueB = 32'h0000_000F;
    @(posedge clock);
    #2;
    reset = 1'b0;
    bus32.start  = 1'b0;
    bus32.valueB = '0;
    #1;
    chk("t6_rst_done", 32'({bus8.done, bus32.done}), 32'd0);
    chk("t6_rst_result", bus32.result | bus8.result, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b1;
    busIdle = 1'b1;
    eventIn = 8'hFF;
    idle(10);
    for (int i = 0; i < 4; i++) ci(32'(i), 32'h0, ID, 1, 0, $sformatf("t6_rd%0d", i));

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
